// File: rtl/muldiv_seq_pkg.sv
// Shared op codes, sequencer state encodings and small op-decoding helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package muldiv_seq_pkg;

    // Op codes driven by the instruction decoder onto the op port.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    localparam int MD_WIDTH_DEFAULT = 32;

    // Operation context captured at launch and held for the whole run.
    typedef struct packed {
        md_op_e op;
        logic   neg_q;   // quotient/product must be negated at the end
        logic   neg_r;   // remainder must be negated at the end
        logic   bz;      // divide with a zero divisor
    } md_ctx_t;

    // op[1] selects divide, op[0] selects unsigned.
    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the control unit and the mul/div sequencer.
// Latency: n/a (wires only).
// Backpressure: none; the master holds off start while busy is high.
// Ports: start/op/a/b launch an operation, wr_hi/wr_lo/wr_data implement
// MTHI/MTLO, busy/done/div_zero report status, hi/lo expose the registers.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Control unit side.
    modport master (
        output start, op, a, b, wr_hi, wr_lo, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    // Sequencer side.
    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wr_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_seq_step.sv
// One iteration of shift-add multiply or restoring divide (combinational).
// Latency: 0 cycles.
// Backpressure: none.
// Ports: mode (0 multiply, 1 divide), acc (upper product / remainder),
// aux (multiplier / quotient), opnd (multiplicand / divisor) -> acc_nxt, aux_nxt.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] aux,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] aux_nxt
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        acc_nxt = acc;
        aux_nxt = aux;

        // Multiply: conditional add keeps the carry in bit WIDTH, which is
        // shifted back down into the accumulator MSB.
        sum = {1'b0, acc} + (aux[0] ? {1'b0, opnd} : '0);

        // Divide: remainder < divisor always holds, so the trial difference
        // lies strictly between -2^WIDTH and 2^WIDTH and WIDTH+1 bits suffice
        // for its sign.
        shifted = {acc, aux[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};

        if (!mode) begin
            acc_nxt = sum[WIDTH:1];
            aux_nxt = {sum[0], aux[WIDTH-1:1]};
        end else begin
            acc_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            aux_nxt = {aux[WIDTH-2:0], ~diff[WIDTH]};
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO register pair.
// Latency: start sampled in cycle 0, done pulses in cycle WIDTH+2 (34 for 32b).
// Backpressure: busy high while running; start and MTHI/MTLO ignored then.
// Ports: clk, reset (sync, active high), bus (muldiv_seq_if.slave).
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    md_state_e        state, state_nxt;
    logic [CW-1:0]    count;
    md_ctx_t          ctx;
    logic [WIDTH-1:0] acc;      // upper product / remainder
    logic [WIDTH-1:0] aux;      // multiplier+low product / quotient
    logic [WIDTH-1:0] opnd;     // multiplicand / divisor
    logic [WIDTH-1:0] a_raw;    // dividend as presented, for divide-by-zero HI
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, div_zero_q;
    logic             accept;

    // Launch-time operand conditioning.
    md_op_e           op_in;
    logic             sgn_in;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;

    // Step results and end-of-run sign fixes.
    logic [WIDTH-1:0]   acc_nxt, aux_nxt;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode    (md_is_div(ctx.op)),
        .acc     (acc),
        .aux     (aux),
        .opnd    (opnd),
        .acc_nxt (acc_nxt),
        .aux_nxt (aux_nxt)
    );

    always_comb begin
        op_in  = md_op_e'(bus.op);
        sgn_in = md_is_signed(op_in);
        a_neg  = sgn_in & bus.a[WIDTH-1];
        b_neg  = sgn_in & bus.b[WIDTH-1];
        // The most negative value maps onto itself, which is the correct
        // unsigned magnitude.
        abs_a  = a_neg ? -bus.a : bus.a;
        abs_b  = b_neg ? -bus.b : bus.b;
    end

    always_comb begin
        prod     = {acc, aux};
        prod_fix = ctx.neg_q ? -prod : prod;
        quo_fix  = ctx.neg_q ? -aux : aux;
        rem_fix  = ctx.neg_r ? -acc : acc;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            MD_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = MD_CALC;
                end
            end
            MD_CALC: begin
                if (count == CW'(WIDTH - 1)) begin
                    state_nxt = MD_FIX;
                end
            end
            MD_FIX:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // State register and datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= MD_IDLE;
            count      <= '0;
            ctx        <= '{op: MD_MULT, neg_q: 1'b0, neg_r: 1'b0, bz: 1'b0};
            acc        <= '0;
            aux        <= '0;
            opnd       <= '0;
            a_raw      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state)
                MD_IDLE: begin
                    // MTHI/MTLO land even when a start arrives in the same
                    // cycle; the result overwrites them at the end.
                    if (bus.wr_hi) hi_q <= bus.wr_data;
                    if (bus.wr_lo) lo_q <= bus.wr_data;
                    if (accept) begin
                        ctx.op    <= op_in;
                        ctx.neg_q <= a_neg ^ b_neg;
                        ctx.neg_r <= a_neg;
                        ctx.bz    <= md_is_div(op_in) & (bus.b == '0);
                        a_raw     <= bus.a;
                        acc       <= '0;
                        count     <= '0;
                        if (md_is_div(op_in)) begin
                            aux  <= abs_a;
                            opnd <= abs_b;
                        end else begin
                            aux  <= abs_b;
                            opnd <= abs_a;
                        end
                    end
                end
                MD_CALC: begin
                    acc   <= acc_nxt;
                    aux   <= aux_nxt;
                    count <= count + 1'b1;
                end
                MD_FIX: begin
                    if (!md_is_div(ctx.op)) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else if (ctx.bz) begin
                        hi_q       <= a_raw;
                        lo_q       <= '1;
                        div_zero_q <= 1'b1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != MD_IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
// Latency: checks done in cycle 34 after the start cycle.
// Backpressure: checks start/MTLO ignored while busy.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;

    muldiv_seq_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic idle_inputs();
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.a       = '0;
        bus.b       = '0;
        bus.wr_hi   = 1'b0;
        bus.wr_lo   = 1'b0;
        bus.wr_data = '0;
    endtask

    // Launches one operation and observes 40 cycles after the start edge.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int done_cyc, output int n_done, output bit busy_ok,
                          output bit stable_ok, output logic [W-1:0] hi_o,
                          output logic [W-1:0] lo_o, output logic dz_o);
        logic [W-1:0] hi0, lo0;
        done_cyc  = -1;
        n_done    = 0;
        busy_ok   = 1'b1;
        stable_ok = 1'b1;
        hi_o      = 'x;
        lo_o      = 'x;
        dz_o      = 1'bx;
        @(negedge clk);
        hi0       = bus.hi;
        lo0       = bus.lo;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (bus.busy !== (cyc <= 33)) busy_ok = 1'b0;
            if (cyc <= 33 && (bus.hi !== hi0 || bus.lo !== lo0)) stable_ok = 1'b0;
            if (bus.done === 1'b1) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    hi_o     = bus.hi;
                    lo_o     = bus.lo;
                    dz_o     = bus.div_zero;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", bus.div_zero); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    endtask

    task automatic test_mult();
        int dc, nd; bit bok, sok; logic [W-1:0] h, l; logic dz;
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, dc, nd, bok, sok, h, l, dz);
        checks++; if (dc !== 34) begin errors++; $display("FAIL mult_done_cycle got %0d want 34", dc); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL mult_done_count got %0d want 1", nd); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL mult_busy_window got %b want 1", bok); end
        checks++; if (sok !== 1'b1) begin errors++; $display("FAIL mult_hilo_stable got %b want 1", sok); end
        checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", h); end
        checks++; if (l !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", l); end
        checks++; if (dz !== 1'b0) begin errors++; $display("FAIL mult_dz got %b want 0", dz); end
    endtask

    task automatic test_multu();
        int dc, nd; bit bok, sok; logic [W-1:0] h, l; logic dz;
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, nd, bok, sok, h, l, dz);
        checks++; if (dc !== 34) begin errors++; $display("FAIL multu_done_cycle got %0d want 34", dc); end
        checks++; if (h !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", h); end
        checks++; if (l !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", l); end
    endtask

    task automatic test_div();
        int dc, nd; bit bok, sok; logic [W-1:0] h, l; logic dz;
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, dc, nd, bok, sok, h, l, dz);
        checks++; if (dc !== 34) begin errors++; $display("FAIL div_done_cycle got %0d want 34", dc); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL div_busy_window got %b want 1", bok); end
        checks++; if (l !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", l); end
        checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", h); end
        run_op(MD_DIVU, 32'd100, 32'd7, dc, nd, bok, sok, h, l, dz);
        checks++; if (l !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want 0000000e", l); end
        checks++; if (h !== 32'd2) begin errors++; $display("FAIL divu_hi got %h want 00000002", h); end
        checks++; if (sok !== 1'b1) begin errors++; $display("FAIL divu_hilo_stable got %b want 1", sok); end
    endtask

    task automatic test_div_edge();
        int dc, nd; bit bok, sok; logic [W-1:0] h, l; logic dz;
        run_op(MD_DIVU, 32'd100, 32'd0, dc, nd, bok, sok, h, l, dz);
        checks++; if (dc !== 34) begin errors++; $display("FAIL dz_done_cycle got %0d want 34", dc); end
        checks++; if (l !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo got %h want ffffffff", l); end
        checks++; if (h !== 32'd100) begin errors++; $display("FAIL dz_hi got %h want 00000064", h); end
        checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", dz); end
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, dc, nd, bok, sok, h, l, dz);
        checks++; if (l !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got %h want 80000000", l); end
        checks++; if (h !== 32'h0) begin errors++; $display("FAIL ovf_hi got %h want 00000000", h); end
        checks++; if (dz !== 1'b0) begin errors++; $display("FAIL ovf_dz got %b want 0", dz); end
    endtask

    task automatic test_start_with_write();
        int dc; logic [W-1:0] h1, h, l;
        dc = -1; h1 = 'x; h = 'x; l = 'x;
        @(negedge clk);
        bus.op = MD_MULTU; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
        bus.wr_hi = 1'b1; bus.wr_data = 32'h77;
        @(posedge clk);
        #1 begin bus.start = 1'b0; bus.wr_hi = 1'b0; end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) h1 = bus.hi;
            if (bus.done === 1'b1 && dc < 0) begin dc = cyc; h = bus.hi; l = bus.lo; end
        end
        checks++; if (h1 !== 32'h77) begin errors++; $display("FAIL sw_write_lands got %h want 00000077", h1); end
        checks++; if (dc !== 34) begin errors++; $display("FAIL sw_done_cycle got %0d want 34", dc); end
        checks++; if (h !== 32'h0) begin errors++; $display("FAIL sw_hi got %h want 00000000", h); end
        checks++; if (l !== 32'd6) begin errors++; $display("FAIL sw_lo got %h want 00000006", l); end
    endtask

    task automatic test_busy_ignore();
        int dc, nd; bit sok; logic [W-1:0] h, l, lo0;
        dc = -1; nd = 0; sok = 1'b1; h = 'x; l = 'x;
        @(negedge clk);
        lo0 = bus.lo;
        bus.op = MD_MULT; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            if (cyc >= 11 && cyc <= 33 && bus.lo !== lo0) sok = 1'b0;
            if (bus.done === 1'b1) begin
                nd++;
                if (dc < 0) begin dc = cyc; h = bus.hi; l = bus.lo; end
            end
            if (cyc == 10) begin
                bus.start = 1'b1; bus.op = MD_DIVU; bus.a = 32'd9; bus.b = 32'd4;
                bus.wr_lo = 1'b1; bus.wr_data = 32'h55;
            end
            if (cyc == 11) begin
                bus.start = 1'b0; bus.wr_lo = 1'b0;
            end
        end
        checks++; if (dc !== 34) begin errors++; $display("FAIL ign_done_cycle got %0d want 34", dc); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", nd); end
        checks++; if (sok !== 1'b1) begin errors++; $display("FAIL ign_wr_lo_busy got %b want 1", sok); end
        checks++; if (h !== 32'h0) begin errors++; $display("FAIL ign_hi got %h want 00000000", h); end
        checks++; if (l !== 32'd6) begin errors++; $display("FAIL ign_lo got %h want 00000006", l); end
    endtask

    task automatic test_reset_abort_and_mthi();
        int nd;
        nd = 0;
        @(negedge clk);
        bus.op = MD_DIV; bus.a = 32'hFFFF_FFF9; bus.b = 32'd2; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int cyc = 1; cyc <= 15; cyc++) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL abort_hi got %h want 00000000", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL abort_lo got %h want 00000000", bus.lo); end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", nd); end

        bus.wr_lo = 1'b1; bus.wr_data = 32'hABCD;
        @(posedge clk);
        #1 bus.wr_lo = 1'b0;
        @(negedge clk);
        bus.wr_hi = 1'b1; bus.wr_data = 32'h1234;
        @(posedge clk);
        #1 bus.wr_hi = 1'b0;
        @(negedge clk);
        checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi got %h want 00001234", bus.hi); end
        checks++; if (bus.lo !== 32'hABCD) begin errors++; $display("FAIL mthi_lo_kept got %h want 0000abcd", bus.lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_edge();
        test_start_with_write();
        test_busy_ignore();
        test_reset_abort_and_mthi();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU. It owns the HI/LO register pair.
- Runs one shift-add (multiply) or restore-subtract (divide) step per clock, so 64-bit products and quotients never pass through the single-cycle ALU.
- Sits beside the main ALU. The control unit stalls on `busy` and reads HI/LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch operation; sampled only while busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  rs operand (multiplicand or dividend)
- b  in  WIDTH  rt operand (multiplier or divisor)
- wr_hi  in  1  MTHI write strobe
- wr_lo  in  1  MTLO write strobe
- wr_data  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; HI/LO valid
- div_zero  out  1  pulses with done when a DIV/DIVU had b=0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE, count=0, hi=0, lo=0, busy=0, done=0, div_zero=0, internal accumulators=0.
- The clock is `clk`; the synchronous active-high reset is `reset`. Reset mid-operation aborts immediately to the reset values and produces no done pulse.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge E0:
  - Latch op.
  - Latch |a| and |b| for signed ops, raw a and b for unsigned ops.
  - Record neg_q = a[W-1]^b[W-1] and neg_r = a[W-1] (signed ops only).
  - Record bz = (b==0) for divides.
  - Clear the accumulator, set count=0, busy=1, go to CALC.
- CALC:
  - Exactly WIDTH steps, at edges E1..E32; count increments each step.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper accumulator with carry (WIDTH+1-bit add). Then shift the {acc, multiplier} pair right by 1.
  - Divide: shift {rem, quo} left by 1. Trial-subtract the divisor from rem (WIDTH+1 bits). If the result is non-negative, keep it and set the quo LSB to 1; otherwise restore.
  - At count==WIDTH-1 go to FIX.
- FIX, edge E33:
  - Multiply: if neg_q, take the 64-bit two's complement of the product. {hi,lo} = product.
  - Divide, bz=0: lo = neg_q ? -quo : quo; hi = neg_r ? -rem : rem.
  - Divide, bz=1: hi = a as latched at E0 (raw, unsigned view), lo = all-ones. No sign fix. div_zero=1.
  - Then busy=0, done=1, state=IDLE.
- done and div_zero are high only for the cycle after E33. busy is high from E0 through E33, exclusive of the cycle after E33.
- Latency: the cycle start is sampled is cycle 0; done is high in cycle 34.
- A new start may be accepted in the done cycle.
- start while busy=1 is ignored; it is not queued.
- wr_hi/wr_lo while busy=1 are ignored; HI/LO are owned by the running operation.
- wr_hi/wr_lo in IDLE update hi/lo at the next edge.
- start and a wr_* strobe in the same IDLE cycle: the write lands at E0 and the operation result overwrites both registers at E33.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No flag, no trap.
- hi/lo are stable and unchanged during CALC; the accumulators are internal.

Decomposition:
- Shared constants include: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU op codes, and state encodings MD_IDLE, MD_CALC, MD_FIX. The decoder that generates `op` uses the same include.
- One natural sub-module: muldiv_step. It is combinational and computes one add-shift or subtract-restore iteration from (mode, acc, aux, operand) to (acc', aux').
- Sequencing, sign handling and the HI/LO registers stay in muldiv_seq.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> cycle 34: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high in cycles 1-33 only.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- Divide by zero and overflow:
  - DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_zero=1 with done.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Start while busy and write while busy:
  - Start MULT 2*3; at cycle 10 pulse start with DIVU and wr_lo=1, wr_data=0x55.
  - Required: both ignored; done at cycle 34 with hi=0, lo=6; no second done.
- Reset and MTHI/MTLO in IDLE:
  - Start DIV; assert reset at cycle 15 -> next cycle busy=0, hi=lo=0; no done ever.
  - Then wr_hi=1, wr_data=0x1234 -> hi=0x1234 next cycle, lo unchanged.
